// File: rtl/fetch_unit.sv
// fetch_unit: program counter, single-outstanding imem req/ack fetch and a 2-entry instruction queue.
// Define FETCH_BYPASS_EN to forward an ack straight to the outputs when the queue is empty.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        ins_valid,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic [5:0]  op,
  output logic [5:0]  fn
);
  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;

  logic [1:0]  state, count, occ;
  logic [31:0] fetch_pc, npc, w0, w1, p0, p1;
  logic        acc, drop, good, byp, pop_q, push, free, issue;

  always_comb begin
    acc = imem_req & imem_ack;
    drop = state == DROP;
    good = acc & ~drop & ~redirect;
`ifdef FETCH_BYPASS_EN
    byp = good & (count == 2'd0);
`else
    byp = 1'b0;
`endif
    pop_q = (count != 2'd0) & ~stall;
    push = good & ~(byp & ~stall);
    occ = redirect ? 2'd0 : count + {1'b0, push} - {1'b0, pop_q};
    // an ack this cycle retires the outstanding request, so a new one may go out on the same edge
    free = ~imem_req | acc;
    issue = free & (occ != 2'd2) & (~drop | redirect);
    npc = redirect ? redirect_pc & ~32'd3 : good ? fetch_pc + 32'd4 : fetch_pc;
  end

  assign ins_valid = (count != 2'd0) | byp;
  assign ins = byp ? imem_data : ins_valid ? w0 : 32'd0;
  assign ins_pc = byp ? imem_addr : ins_valid ? p0 : 32'd0;
  assign op = ins[31:26];
  assign fn = ins[5:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      count <= 2'd0;
      fetch_pc <= RESET_PC;
      imem_req <= 1'b0;
      imem_addr <= RESET_PC;
      w0 <= 32'd0;
      w1 <= 32'd0;
      p0 <= 32'd0;
      p1 <= 32'd0;
    end else begin
      fetch_pc <= npc;
      count <= occ;
      imem_req <= issue | ~free;
      if (issue) imem_addr <= npc;
      state <= ~free ? ((redirect | drop) ? DROP : FETCH) : (issue | drop) ? FETCH : HOLD;
      if (pop_q) begin
        w0 <= w1;
        p0 <= p1;
      end
      if (push) begin
        if (count == {1'b0, pop_q}) begin
          w0 <= imem_data;
          p0 <= imem_addr;
        end else begin
          w1 <= imem_data;
          p1 <= imem_addr;
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized stall/redirect/latency traffic against a stream-level reference model.
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req, imem_ack, redirect, stall, ins_valid;
  logic [31:0] imem_addr, imem_data, redirect_pc, ins, ins_pc;
  logic [5:0]  op, fn;

  int vec = 0;
  int errs = 0;
  logic [31:0] exp_req_pc, exp_cons_pc, prev_addr;
  logic        stale, exp_req, prev_req, prev_ack, model_on, auto_mem;
  int          buf_cnt, wait_cnt, lat;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .ins_valid(ins_valid), .ins(ins), .ins_pc(ins_pc), .op(op), .fn(fn)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    exp_req_pc = RPC;
    exp_cons_pc = RPC;
    buf_cnt = 0;
    stale = 0;
    exp_req = 0;
    prev_req = 0;
    prev_ack = 0;
    prev_addr = 0;
    model_on = 1;
  endtask

  // Check the current cycle against the model, advance the model, then clock and let memory respond.
  task automatic cyc();
    logic acc, disc, cons, out_after;
    int bn;
    logic [31:0] e;
    if (model_on) begin
      chk("req", 32'(imem_req), 32'(exp_req));
      if (imem_req && (!prev_req || prev_ack)) begin
        chk("req_addr", imem_addr, exp_req_pc);
        exp_req_pc += 32'd4;
      end else if (imem_req) chk("addr_stable", imem_addr, prev_addr);
      chk("valid", 32'(ins_valid), 32'(buf_cnt != 0));
      if (ins_valid) begin
        e = memw(ins_pc);
        chk("ins", ins, e);
        chk("op", 32'(op), 32'(e[31:26]));
        chk("fn", 32'(fn), 32'(e[5:0]));
      end
      cons = (buf_cnt != 0) && !stall;
      if (cons) begin
        chk("ins_pc", ins_pc, exp_cons_pc);
        exp_cons_pc += 32'd4;
      end
      acc = imem_req & imem_ack;
      disc = stale | redirect;
      bn = redirect ? 0 : buf_cnt + int'(acc && !disc) - int'(cons);
      out_after = imem_req & !imem_ack;
      exp_req = out_after || (bn < 2 && !(stale && acc && !redirect));
      stale = out_after && (stale || redirect);
      if (redirect) begin
        exp_req_pc = redirect_pc & ~32'h3;
        exp_cons_pc = redirect_pc & ~32'h3;
      end
      buf_cnt = bn;
    end
    prev_req = imem_req;
    prev_ack = imem_ack;
    prev_addr = imem_addr;
    @(posedge clock);
    #1;
    redirect = 0;
    if (imem_req) begin
      wait_cnt = (prev_req && !prev_ack) ? wait_cnt + 1 : 0;
      imem_ack = auto_mem && (wait_cnt >= lat);
      imem_data = memw(imem_addr);
    end else begin
      imem_ack = 0;
      imem_data = $urandom;
    end
  endtask

  initial begin
    stall = 0; redirect = 0; redirect_pc = 0; imem_ack = 0; imem_data = 0;
    auto_mem = 1; lat = 1; model_on = 0; wait_cnt = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_valid", 32'(ins_valid), 32'd0);
    chk("rst_ins", ins, 32'd0);
    chk("rst_pc", ins_pc, 32'd0);
    chk("rst_opfn", {20'd0, op, fn}, 32'd0);
    // release with a stray ack that must be ignored
    reset = 1;
    model_init();
    imem_ack = 1;
    imem_data = 32'hDEAD_BEEF;
    cyc();
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h100);
    cyc();
    cyc();
    chk("lat1_valid", 32'(ins_valid), 32'd1);
    chk("lat1_pc", ins_pc, 32'h100);
    chk("lat1_ins", ins, memw(32'h100));
    chk("seq_addr1", imem_addr, 32'h104);
    cyc();
    cyc();
    chk("seq_addr2", imem_addr, 32'h108);
    chk("seq_pc2", ins_pc, 32'h104);
    // hold: stall fills the queue, requests stop
    stall = 1;
    repeat (10) cyc();
    chk("hold_req", 32'(imem_req), 32'd0);
    chk("hold_valid", 32'(ins_valid), 32'd1);
    chk("hold_head", ins_pc, 32'h104);
    stall = 0;
    cyc();
    chk("pop_next", ins_pc, 32'h108);
    chk("resume_req", 32'(imem_req), 32'd1);
    chk("resume_addr", imem_addr, 32'h10C);
    // redirect while a request is outstanding; ack comes 3 cycles after it was issued
    for (int i = 0; i < 40; i++) begin
      if (imem_req && wait_cnt == 0 && imem_addr == 32'h118) break;
      cyc();
    end
    chk("drop_start", imem_addr, 32'h118);
    lat = 3;
    redirect = 1;
    redirect_pc = 32'h203;
    cyc();
    chk("drop_req1", 32'(imem_req), 32'd1);
    chk("drop_addr1", imem_addr, 32'h118);
    chk("drop_valid1", 32'(ins_valid), 32'd0);
    cyc();
    chk("drop_addr2", imem_addr, 32'h118);
    cyc();
    chk("drop_ack", 32'(imem_ack), 32'd1);
    chk("drop_addr3", imem_addr, 32'h118);
    cyc();
    chk("drop_idle", 32'(imem_req), 32'd0);
    chk("drop_valid4", 32'(ins_valid), 32'd0);
    cyc();
    chk("drop_new_req", 32'(imem_req), 32'd1);
    chk("drop_new_addr", imem_addr, 32'h200);
    // redirect in the same cycle as an ack
    lat = 1;
    for (int i = 0; i < 20 && !imem_ack; i++) cyc();
    redirect = 1;
    redirect_pc = 32'h3F1;
    cyc();
    chk("ackredir_valid", 32'(ins_valid), 32'd0);
    chk("ackredir_req", 32'(imem_req), 32'd1);
    chk("ackredir_addr", imem_addr, 32'h3F0);
    // address wrap
    redirect = 1;
    redirect_pc = 32'hFFFF_FFF8;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (imem_req && wait_cnt == 0 && imem_addr != 32'hFFFF_FFF8 && imem_addr != 32'hFFFF_FFFC) break;
    end
    chk("wrap_addr", imem_addr, 32'h0);
    for (int i = 0; i < 40; i++) begin
      if (ins_valid && ins_pc != 32'hFFFF_FFF8 && ins_pc != 32'hFFFF_FFFC) break;
      cyc();
    end
    chk("wrap_ins_pc", ins_pc, 32'h0);
    // reset with a request in flight, stray ack after release
    lat = 50;
    for (int i = 0; i < 20 && !imem_req; i++) cyc();
    cyc();
    reset = 0;
    #1;
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_addr", imem_addr, RPC);
    chk("mid_rst_valid", 32'(ins_valid), 32'd0);
    chk("mid_rst_ins", ins, 32'd0);
    model_on = 0;
    cyc();
    cyc();
    reset = 1;
    model_init();
    imem_ack = 1;
    imem_data = 32'h1234_5678;
    lat = 1;
    cyc();
    chk("rel_addr", imem_addr, RPC);
    chk("rel_req", 32'(imem_req), 32'd1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(3) == 0);
      lat = $urandom_range(3, 1);
      if (!imem_req && $urandom_range(7) == 0) imem_ack = 1;
      if ($urandom_range(19) == 0) begin
        redirect = 1;
        redirect_pc = $urandom_range(1) ? $urandom : 32'hFFFF_FFF0 + $urandom_range(15);
      end
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
